// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART-style serializer. One start bit, eight data bits
// LSB first, one stop bit; each slot is held for CLKS_PER_BIT clocks.
module serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       R,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       tx,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state, state_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic       tx_n, done_n;
    logic       slot_end;

    assign slot_end = (cnt == LAST);
    assign ready    = (state == IDLE);
    assign busy     = ~ready;

    // Next-state and next-datapath values; tx is computed one cycle ahead
    // so the line itself always comes straight out of a flop.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = slot_end ? 8'd0 : cnt + 8'd1;
        idx_n   = idx;
        tx_n    = tx;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                tx_n  = 1'b1;
                if (load) begin
                    shreg_n = data;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (slot_end) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (slot_end) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        // Next slot shows the bit that is about to reach bit 0.
                        tx_n = shreg[1];
                    end
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame with the line high.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state <= IDLE;
            shreg <= 8'h00;
            cnt   <= 8'd0;
            idx   <= 3'd0;
            tx    <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            tx    <= tx_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a table of frames on a CLKS_PER_BIT=4 instance plus
// hand-written sequences for back-to-back, reset abort and idle hold.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       r4, r1;
    logic [7:0] data4, data1;
    logic       load4, load1;
    logic       ready4, busy4, tx4, done4;
    logic       ready1, busy1, tx1, done1;

    int checks = 0;
    int errors = 0;
    int done4_cnt = 0;
    int done1_cnt = 0;

    always #5 clk = ~clk;

    serial_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .R(r4), .data(data4), .load(load4),
        .ready(ready4), .busy(busy4), .tx(tx4), .done(done4)
    );

    serial_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .R(r1), .data(data1), .load(load1),
        .ready(ready1), .busy(busy1), .tx(tx1), .done(done1)
    );

    always @(negedge clk) begin
        if (done4 === 1'b1) done4_cnt++;
        if (done1 === 1'b1) done1_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // mode 0: plain frame; 1: data scrambled every cycle; 2: second load at cycle 12
    typedef struct {
        logic [7:0] din;
        int         mode;
        logic [9:0] frame;  // bit i = expected tx level in slot i
    } vec_t;

    vec_t vecs[5];

    // Load a byte into dut4 and check all 40 frame cycles plus the done cycle.
    task automatic send4(input logic [7:0] d, input int mode, input logic [9:0] frame);
        @(negedge clk);
        chk("pre_ready", ready4, 1);
        data4 = d;
        load4 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) load4 = 1'b0;
            chk($sformatf("tx_c%0d", c), tx4, frame[c / 4]);
            chk("busy_ready", {busy4, ready4}, 2'b10);
            chk("done_low", done4, 0);
            if (mode == 1) data4 = 8'($urandom);
            if (mode == 2 && c == 12) begin load4 = 1'b1; data4 = 8'hFF; end
            if (mode == 2 && c == 13) load4 = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", {done4, ready4, busy4, tx4}, 4'b1101);
        @(negedge clk);
        chk("done_one_cycle", {done4, ready4, tx4}, 3'b011);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 0, 10'h34A};
        vecs[1] = '{8'h3C, 2, 10'h278};
        vecs[2] = '{8'h81, 1, 10'h302};
        vecs[3] = '{8'h00, 0, 10'h200};
        vecs[4] = '{8'hFF, 0, 10'h3FE};

        r4 = 1'b1; r1 = 1'b1;
        data4 = 8'h00; data1 = 8'h00;
        load4 = 1'b0; load1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset4", {tx4, ready4, busy4, done4}, 4'b1100);
        chk("reset1", {tx1, ready1, busy1, done1}, 4'b1100);
        r4 = 1'b0; r1 = 1'b0;

        // Idle hold: nothing moves without load.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle4", {tx4, ready4, busy4, done4}, 4'b1100);
        end

        foreach (vecs[i]) send4(vecs[i].din, vecs[i].mode, vecs[i].frame);

        // CLKS_PER_BIT=1: 8'h00 then 8'hFF loaded on the done cycle.
        @(negedge clk);
        data1 = 8'h00; load1 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) load1 = 1'b0;
            chk($sformatf("b2b_a_s%0d", c), {tx1, ready1, done1}, {(c == 9), 2'b00});
        end
        @(negedge clk);
        chk("b2b_done_a", {done1, ready1, tx1}, 3'b111);
        data1 = 8'hFF; load1 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) load1 = 1'b0;
            chk($sformatf("b2b_b_s%0d", c), {tx1, ready1, done1}, {(c != 0), 2'b00});
        end
        @(negedge clk);
        chk("b2b_done_b", {done1, ready1, tx1}, 3'b111);
        repeat (3) @(negedge clk);
        chk("b2b_two_dones", done1_cnt, 2);

        // Abort a frame at cycle 17 with an asynchronous reset.
        @(negedge clk);
        data4 = 8'hA5; load4 = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) load4 = 1'b0;
            chk("abort_pre_tx", tx4, vecs[0].frame[c / 4]);
        end
        #2 r4 = 1'b1;
        #1 chk("abort_async", {tx4, ready4, busy4, done4}, 4'b1100);
        @(negedge clk);
        chk("abort_held", {tx4, ready4, busy4, done4}, 4'b1100);
        r4 = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            chk("abort_no_done", {tx4, ready4, done4}, 3'b110);
        end
        send4(8'h55, 0, 10'h2AA);
        chk("done4_total", done4_cnt, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, number of clk cycles each serial bit is held on tx; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 R  input  1  asynchronous, active-high reset; R=1 forces reset state independent of clk.
REQ-004 data  input  8  parallel byte to transmit; sampled only on an accepted load.
REQ-005 load  input  1  request to transmit data; accepted on a rising clk edge when load=1 and ready=1.
REQ-006 ready  output  1  block idle and able to accept load.
REQ-007 busy  output  1  frame in progress; always the inverse of ready.
REQ-008 tx  output  1  serial line; idle level 1.
REQ-009 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10 bit slots total.
REQ-011 Each bit slot SHALL drive tx constant for exactly CLKS_PER_BIT clk cycles, so one frame occupies 10*CLKS_PER_BIT cycles.
REQ-012 State machine states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: tx=1, ready=1; an accepted load latches data into an internal 8-bit shift register and moves to START on the same edge.
REQ-014 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-015 DATA: tx = shift register bit 0; at end of each slot, shift right by one and increment a 3-bit bit index; after the slot with index 7, move to STOP.
REQ-016 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-017 done SHALL be 1 for exactly the first IDLE cycle after STOP and 0 at all other times.
REQ-018 The cycle counter SHALL be 8 bits, cleared at every slot boundary and on entry to START; it counts 0..CLKS_PER_BIT-1 and wraps to 0 at slot end.
REQ-019 With CLKS_PER_BIT=1, every slot SHALL last exactly one cycle; no slot may be skipped or doubled.
REQ-020 ready SHALL be 1 in IDLE and 0 in START, DATA and STOP; load while ready=0 SHALL be ignored with no queuing.
REQ-021 A load in the same cycle as done=1 SHALL be accepted; successive frames are separated by exactly one idle tx=1 cycle.
REQ-022 Changes on data after acceptance SHALL NOT affect the frame in progress.
REQ-023 tx SHALL be driven from a register, glitch-free, changing only on clk rising edges (or on R assertion).

Reset
REQ-024 While R=1: state=IDLE, tx=1, ready=1, busy=0, done=0, shift register=8'h00, bit index=0, cycle counter=0.
REQ-025 R asserted mid-frame SHALL abort the frame immediately (asynchronously) with tx=1; no done pulse SHALL be issued for the aborted frame.
REQ-026 After R deasserts, the first rising edge with load=1 SHALL be accepted normally.

Verification
REQ-027 CLKS_PER_BIT=4, load data=8'hA5 -> tx slots 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles), then done=1 for 1 cycle with ready=1.
REQ-028 CLKS_PER_BIT=1, load 8'h00 then load 8'hFF on the done cycle -> tx 0,0x8,1, one idle 1, 0,1x8,1; exactly two done pulses.
REQ-029 Load 8'h3C, assert load again with 8'hFF at cycle 12 of the frame -> second load ignored; frame carries 8'h3C; ready stays 0 until done.
REQ-030 Load 8'h81, change data every cycle during the frame -> serial data bits remain 1,0,0,0,0,0,0,1.
REQ-031 Assert R at cycle 17 of a frame (CLKS_PER_BIT=4) between clk edges -> tx=1, ready=1 before the next edge; no done; a fresh load of 8'h55 after release transmits correctly.
REQ-032 Hold load=0 for 100 cycles after reset -> tx=1, ready=1, busy=0, done=0 throughout.
